uart_tx_queue_drain: RTL and testbench

//  - Consumer end of the memory-mapped UART TX queue: drains the 256-byte buffer at ff000000-ff0000ff.
//  - The CPU writes bytes and advances the tail (ff000100); this block serialises each byte 8N1 on uart_tx and advances the head (ff000104).
//  - Sits beside the memory block. tx_buffer/tx_queue_tail come from memory; tx_queue_head goes back to it.

---
 rtl/uart_tx_queue_drain_pkg.sv | 21 ++
 rtl/uart_tx_queue_drain_if.sv | 21 ++
 rtl/uart_tx_queue_drain_baud.sv | 35 +++
 rtl/uart_tx_queue_drain.sv | 120 ++++++++++++
 tb/tb_uart_tx_queue_drain.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_queue_drain_pkg.sv
// Shared types and memory-map constants for the UART TX queue drain block.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [31:0] TX_BUFFER_OFFSET = 32'hff000000;
    localparam logic [31:0] TX_TAIL_OFFSET   = 32'hff000100;
    localparam logic [31:0] TX_HEAD_OFFSET   = 32'hff000104;

    localparam int unsigned QUEUE_BYTES = 256;
    localparam int unsigned BUF_WORDS   = QUEUE_BYTES / 4;
    localparam int unsigned IDX_W       = 8;
    localparam int unsigned WORD_W      = 32;

endpackage

// File: rtl/uart_tx_queue_drain_if.sv
// Memory-side view of the TX queue: buffer storage, CPU tail and drain head.
interface uart_tx_queue_drain_if;
    import uart_tx_pkg::*;

    logic [WORD_W-1:0] tx_buffer [BUF_WORDS];
    logic [WORD_W-1:0] tx_queue_tail;
    logic [WORD_W-1:0] tx_queue_head;

    modport master (
        output tx_buffer,
        output tx_queue_tail,
        input  tx_queue_head
    );

    modport slave (
        input  tx_buffer,
        input  tx_queue_tail,
        output tx_queue_head
    );

endinterface

// File: rtl/uart_tx_queue_drain_baud.sv
// Bit-period counter: tick pulses on the last clk of every bit; clear restarts a bit.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt + CNT_W'(1);
        if (clear || (cnt == LAST)) begin
            cnt_next = '0;
        end
    end

    // tick is registered against the next count so it lines up with cnt == LAST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            tick <= (cnt_next == LAST);
        end
    end

endmodule

// File: rtl/uart_tx_queue_drain.sv
// Drains the 256-byte memory-mapped TX queue onto a UART line (8N1).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_queue_drain
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_tx_queue_drain_if.slave  mem,
    output logic                  uart_tx,
    output logic                  busy
);

    state_t             state;
    logic [IDX_W-1:0]   head;
    logic [IDX_W-1:0]   tail;
    logic [7:0]         shreg;
    logic [2:0]         bit_cnt;
    logic [WORD_W-1:0]  cur_word;
    logic [7:0]         cur_byte;
    logic               start_frame;
    logic               tick;
    logic               unused_tail;
`ifdef UART_TX_PARITY_EN
    logic               parity;
`endif

    assign tail        = mem.tx_queue_tail[IDX_W-1:0];
    assign unused_tail = ^mem.tx_queue_tail[WORD_W-1:IDX_W];
    assign cur_word    = mem.tx_buffer[head[IDX_W-1:2]];
    assign cur_byte    = cur_word[{head[1:0], 3'b000} +: 8];
    assign start_frame = (state == IDLE) && (head != tail);

    assign mem.tx_queue_head = {(WORD_W-IDX_W)'(0), head};

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_frame),
        .tick  (tick)
    );

    // Line value is registered on each state transition so it changes on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            head    <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            uart_tx <= 1'b1;
            busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_frame) begin
                        shreg   <= cur_byte;
                        uart_tx <= 1'b0;
                        busy    <= 1'b1;
                        state   <= START;
`ifdef UART_TX_PARITY_EN
                        parity  <= ^cur_byte;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        uart_tx <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            uart_tx <= parity;
                            state   <= PARITY;
`else
                            uart_tx <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            uart_tx <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        uart_tx <= 1'b1;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        head  <= head + IDX_W'(1);
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_queue_drain.sv
// Scoreboard bench for uart_tx_queue_drain: a line monitor decodes frames and pops expected bytes.
module tb_uart_tx_queue_drain;

    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned BITS = 11;
`else
    localparam int unsigned BITS = 10;
`endif
    localparam int unsigned FRAME = BITS * CPB;

    logic clk = 1'b0;
    logic rst_n;
    logic uart_tx;
    logic busy;
    int   cyc = 0;

    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0] sb[$];
    int         starts[$];

    uart_tx_queue_drain_if mem ();

    uart_tx_queue_drain #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem     (mem),
        .uart_tx (uart_tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem.tx_queue_tail = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_head(input logic [7:0] h, input int budget);
        int n;
        n = 0;
        while ((mem.tx_queue_head !== {24'd0, h}) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check("head_reached", mem.tx_queue_head, {24'd0, h});
    endtask

    // Line monitor: detect start bit, sample mid-bit, compare against the scoreboard
    initial begin : monitor
        logic [7:0] b;
        logic       aborted;
        logic       stop_bit;
        logic       start_bit;
`ifdef UART_TX_PARITY_EN
        logic       par_bit;
`endif
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uart_tx === 1'b0) begin
                starts.push_back(cyc);
                aborted = 1'b0;
                repeat (CPB / 2) @(negedge clk);
                start_bit = uart_tx;
                if (!rst_n) aborted = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                    b[i] = uart_tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                if (!rst_n) aborted = 1'b1;
                par_bit = uart_tx;
`endif
                repeat (CPB) @(negedge clk);
                if (!rst_n) aborted = 1'b1;
                stop_bit = uart_tx;
                if (aborted) begin
                    if (starts.size() > 0) void'(starts.pop_back());
                end else begin
                    check("start_bit", {31'd0, start_bit}, 32'd0);
                    check("stop_bit", {31'd0, stop_bit}, 32'd1);
                    check("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
                    if (sb.size() != 0) begin
                        logic [7:0] e;
                        e = sb.pop_front();
                        check("rx_byte", {24'd0, b}, {24'd0, e});
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", {31'd0, par_bit}, {31'd0, ^e});
`endif
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic       line_low;
        logic [7:0] bytes [256];

        rst_n = 1'b0;
        mem.tx_queue_tail = 32'd0;
        for (int i = 0; i < 64; i++) mem.tx_buffer[i] = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_head", mem.tx_queue_head, 32'd0);

        rst_n = 1'b1;
        line_low = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) line_low = 1'b1;
        end
        check("idle_quiet", {31'd0, line_low}, 32'd0);
        check("idle_head", mem.tx_queue_head, 32'd0);

        // Single byte with exact edge timing
        mem.tx_buffer[0] = 32'h00000041;
        sb.push_back(8'h41);
        mem.tx_queue_tail = 32'd1;
        @(negedge clk);
        check("start_latency_line", {31'd0, uart_tx}, 32'd0);
        check("start_latency_busy", {31'd0, busy}, 32'd1);
        repeat (FRAME - 1) @(negedge clk);
        check("pre_end_head", mem.tx_queue_head, 32'd0);
        check("pre_end_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("end_head", mem.tx_queue_head, 32'd1);
        check("end_busy", {31'd0, busy}, 32'd0);
        repeat (10) @(negedge clk);
        check("single_drained", sb.size(), 32'd0);

        // Byte order and back-to-back spacing
        do_reset();
        starts.delete();
        mem.tx_buffer[0] = 32'h44434241;
        sb.push_back(8'h41); sb.push_back(8'h42); sb.push_back(8'h43); sb.push_back(8'h44);
        mem.tx_queue_tail = 32'd4;
        wait_head(8'd4, 4 * (FRAME + 1) + 50);
        repeat (10) @(negedge clk);
        check("b2b_frames", starts.size(), 32'd4);
        for (int i = 1; i < starts.size(); i++)
            check("b2b_gap", 32'(starts[i] - starts[i-1]), FRAME + 1);
        check("b2b_drained", sb.size(), 32'd0);

        // Mid-frame buffer overwrite and tail advance
        do_reset();
        mem.tx_buffer[0] = 32'h00002211;
        sb.push_back(8'h11);
        mem.tx_queue_tail = 32'd1;
        repeat (10) @(negedge clk);
        mem.tx_buffer[0] = 32'h000022EE;
        mem.tx_queue_tail = 32'd2;
        sb.push_back(8'h22);
        wait_head(8'd2, 3 * (FRAME + 1) + 50);
        repeat (5) @(negedge clk);
        check("midframe_drained", sb.size(), 32'd0);

        // Reset during DATA: line snaps high, partial byte dropped
        mem.tx_queue_tail = 32'd3;
        @(negedge clk);
        repeat (3 * CPB) @(negedge clk);
        check("mid_data_low", {31'd0, uart_tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_line", {31'd0, uart_tx}, 32'd1);
        check("async_rst_head", mem.tx_queue_head, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        mem.tx_queue_tail = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (FRAME + 20) @(negedge clk);
        check("no_stale_byte", sb.size(), 32'd0);

        // Wrap-around: drain 254 bytes, then send 254/255 and wrap head to 0
        do_reset();
        for (int k = 0; k < 252; k++) bytes[k] = 8'((k * 7 + 3) & 255);
        bytes[252] = 8'h34; bytes[253] = 8'h12; bytes[254] = 8'h55; bytes[255] = 8'hAA;
        for (int w = 0; w < 64; w++)
            mem.tx_buffer[w] = {bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w]};
        for (int k = 0; k < 254; k++) sb.push_back(bytes[k]);
        mem.tx_queue_tail = 32'd254;
        wait_head(8'd254, 254 * (FRAME + 1) + 100);
        check("pre_wrap_drained", sb.size(), 32'd0);
        sb.push_back(8'h55);
        sb.push_back(8'hAA);
        mem.tx_queue_tail = 32'd0;
        wait_head(8'd0, 2 * (FRAME + 1) + 50);
        line_low = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) line_low = 1'b1;
        end
        check("wrap_idle", {31'd0, line_low}, 32'd0);
        check("wrap_head", mem.tx_queue_head, 32'd0);
        check("wrap_drained", sb.size(), 32'd0);

        // Parity-sensitive bytes (parity bit checked by the monitor when enabled)
        do_reset();
        mem.tx_buffer[0] = 32'h00000703;
        sb.push_back(8'h03);
        sb.push_back(8'h07);
        mem.tx_queue_tail = 32'd2;
        wait_head(8'd2, 2 * (FRAME + 1) + 50);
        repeat (5) @(negedge clk);
        check("parity_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
